// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and
// the address alignment/range check applied before any memory strobe.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int ALIGN_MSB = 2;   // doubleword accesses only
  localparam int RANGE_LSB = 13;  // addr[63:13] selects the memory

  function automatic logic addr_ok(input logic [63:0] addr, input logic [50:0] base);
    return (addr[ALIGN_MSB:0] == '0) && (addr[63:RANGE_LSB] == base);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's request/response bundle for the memory arbiter; requesters
// use the master view, the arbiter side uses the slave view.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ack;
  logic        err;
  logic [63:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters access to a 64-doubleword memory.
// Accepted access acks two edges after the req is sampled, rejected ones after one.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [50:0] BASE_ADDRESS = 51'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_data_in,
  input  logic [63:0] mem_data_out
);

  state_t      state_q, state_d;
  logic        last_q, last_d;   // 1: requester 1 was served last
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [63:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [63:0] mem_address_q, mem_address_d, mem_data_in_q, mem_data_in_d;

  logic        sel;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        resp_vld;
  logic        resp_err;
  logic [63:0] resp_dat;

  // On a tie the requester not served last wins.
  assign sel       = (req0 && req1) ? ~last_q : req1;
  assign sel_we    = sel ? we1    : we0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    win_d         = win_q;
    we_d          = we_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    err0_d        = 1'b0;
    err1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    resp_vld      = 1'b0;
    resp_err      = 1'b0;
    resp_dat      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          win_d  = sel;
          last_d = sel;
          we_d   = sel_we;
          if (addr_ok(sel_addr, BASE_ADDRESS)) begin
            state_d       = ST_ACCESS;
            mem_address_d = sel_addr;
            mem_data_in_d = sel_wdata;
            mem_write_d   = sel_we;
            mem_read_d    = ~sel_we;
          end else begin
            state_d  = ST_RESP;
            resp_vld = 1'b1;
            resp_err = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        resp_vld = 1'b1;
        resp_dat = we_q ? 64'd0 : mem_data_out;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (resp_vld) begin
      if (win_d) begin
        ack1_d   = 1'b1;
        err1_d   = resp_err;
        rdata1_d = resp_dat;
      end else begin
        ack0_d   = 1'b1;
        err0_d   = resp_err;
        rdata0_d = resp_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      win_q         <= win_d;
      we_q          <= we_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64-doubleword memory:
// reads, writes, round-robin ties, rejected addresses and reset during a write.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_data_in, mem_data_out;

  mem_arbiter_if rq0 ();
  mem_arbiter_if rq1 ();

  mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0         (rq0.req),
    .req1         (rq1.req),
    .we0          (rq0.we),
    .we1          (rq1.we),
    .addr0        (rq0.addr),
    .addr1        (rq1.addr),
    .wdata0       (rq0.wdata),
    .wdata1       (rq1.wdata),
    .ack0         (rq0.ack),
    .ack1         (rq1.ack),
    .err0         (rq0.err),
    .err1         (rq1.err),
    .rdata0       (rq0.rdata),
    .rdata1       (rq1.rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Memory model; the bench preloads words through the poke port during reset.
  logic [63:0] mem [64];
  logic        poke_vld;
  logic [5:0]  poke_idx;
  logic [63:0] poke_dat;

  assign mem_data_out = mem[mem_address[8:3]];

  always @(posedge clk) begin
    if (poke_vld) mem[poke_idx] <= poke_dat;
    else if (mem_write) mem[mem_address[8:3]] <= mem_data_in;
  end

  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, ack_cnt = 0;
  logic [63:0] strobe_addr = '0, strobe_dat = '0;

  always @(negedge clk) begin
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (rq0.ack && rq1.ack) both_cnt <= both_cnt + 1;
    if (rq0.ack || rq1.ack) ack_cnt <= ack_cnt + 1;
    if (mem_read || mem_write) begin
      strobe_addr <= mem_address;
      strobe_dat  <= mem_data_in;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [63:0] dat);
    poke_vld = 1'b1;
    poke_idx = idx;
    poke_dat = dat;
    tick();
    poke_vld = 1'b0;
  endtask

  // Issue one access, measure edges until ack, check response, release req.
  task automatic access(input bit port, input bit we, input logic [63:0] addr,
                        input logic [63:0] wd, input int exp_lat, input bit exp_err,
                        input logic [63:0] exp_rd, input string tag);
    int lat;
    bit got;
    if (port) begin
      rq1.we = we; rq1.addr = addr; rq1.wdata = wd; rq1.req = 1'b1;
    end else begin
      rq0.we = we; rq0.addr = addr; rq0.wdata = wd; rq0.req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      got = port ? rq1.ack : rq0.ack;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " err"}, port ? 64'(rq1.err) : 64'(rq0.err), 64'(exp_err));
    check_eq({tag, " rdata"}, port ? rq1.rdata : rq0.rdata, exp_rd);
    check_eq({tag, " other ack"}, port ? 64'(rq0.ack) : 64'(rq1.ack), 64'd0);
    rq0.req = 1'b0;
    rq1.req = 1'b0;
    tick();
    check_eq({tag, " ack drop"}, port ? 64'(rq1.ack) : 64'(rq0.ack), 64'd0);
  endtask

  initial begin
    int s_rd, s_wr, s_both, s_ack, grants;
    bit who;

    reset_n  = 1'b0;
    poke_vld = 1'b0;
    poke_idx = '0;
    poke_dat = '0;
    rq0.req = 1'b0; rq0.we = 1'b0; rq0.addr = '0; rq0.wdata = '0;
    rq1.req = 1'b0; rq1.we = 1'b0; rq1.addr = '0; rq1.wdata = '0;

    poke(6'd0, 64'h100);
    poke(6'd1, 64'h111);
    poke(6'd2, 64'd2);
    poke(6'd3, 64'd0);
    poke(6'd5, 64'h55);

    check_eq("rst ack0", 64'(rq0.ack), 64'd0);
    check_eq("rst ack1", 64'(rq1.ack), 64'd0);
    check_eq("rst err0", 64'(rq0.err), 64'd0);
    check_eq("rst err1", 64'(rq1.err), 64'd0);
    check_eq("rst mem_read", 64'(mem_read), 64'd0);
    check_eq("rst mem_write", 64'(mem_write), 64'd0);
    check_eq("rst mem_address", mem_address, 64'd0);
    check_eq("rst mem_data_in", mem_data_in, 64'd0);
    check_eq("rst rdata0", rq0.rdata, 64'd0);
    check_eq("rst rdata1", rq1.rdata, 64'd0);

    reset_n = 1'b1;
    tick();

    // Plain read of a preloaded word.
    s_rd = rd_cnt; s_wr = wr_cnt;
    access(1'b0, 1'b0, 64'h10, 64'd0, 2, 1'b0, 64'd2, "rd0 0x10");
    check_eq("rd0 read cycles", 64'(rd_cnt - s_rd), 64'd1);
    check_eq("rd0 write cycles", 64'(wr_cnt - s_wr), 64'd0);
    check_eq("rd0 strobe addr", strobe_addr, 64'h10);

    // Write from port 1, then read it back on port 0.
    s_rd = rd_cnt; s_wr = wr_cnt;
    access(1'b1, 1'b1, 64'h18, 64'hDEAD, 2, 1'b0, 64'd0, "wr1 0x18");
    check_eq("wr1 write cycles", 64'(wr_cnt - s_wr), 64'd1);
    check_eq("wr1 read cycles", 64'(rd_cnt - s_rd), 64'd0);
    check_eq("wr1 strobe data", strobe_dat, 64'hDEAD);
    check_eq("wr1 mem word", mem[3], 64'hDEAD);
    access(1'b0, 1'b0, 64'h18, 64'd0, 2, 1'b0, 64'hDEAD, "rd0 0x18");

    // Round robin from a fresh reset with both requests held.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    s_both = both_cnt;
    rq0.we = 1'b0; rq0.addr = 64'h0; rq0.req = 1'b1;
    rq1.we = 1'b0; rq1.addr = 64'h8; rq1.req = 1'b1;
    grants = 0;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      tick();
      if (rq0.ack || rq1.ack) begin
        who = rq1.ack;
        check_eq($sformatf("rr grant %0d", grants), 64'(who), 64'(grants % 2));
        check_eq($sformatf("rr rdata %0d", grants), who ? rq1.rdata : rq0.rdata,
                 who ? 64'h111 : 64'h100);
        grants++;
      end
    end
    check_eq("rr grant count", 64'(grants), 64'd4);
    rq0.req = 1'b0;
    rq1.req = 1'b0;
    tick();
    tick();
    check_eq("rr simultaneous acks", 64'(both_cnt - s_both), 64'd0);

    // Rejected accesses: misaligned and out of range.
    s_rd = rd_cnt; s_wr = wr_cnt;
    access(1'b0, 1'b0, 64'h0C, 64'd0, 1, 1'b1, 64'd0, "unaligned");
    access(1'b0, 1'b0, 64'h2000, 64'd0, 1, 1'b1, 64'd0, "out of range");
    access(1'b1, 1'b1, 64'h2008, 64'h77, 1, 1'b1, 64'd0, "oor write");
    check_eq("reject read cycles", 64'(rd_cnt - s_rd), 64'd0);
    check_eq("reject write cycles", 64'(wr_cnt - s_wr), 64'd0);

    // Reset asserted while a write is in its access cycle.
    s_ack = ack_cnt;
    rq1.we = 1'b1; rq1.addr = 64'h28; rq1.wdata = 64'h1234; rq1.req = 1'b1;
    tick();
    check_eq("rstw mem_write in access", 64'(mem_write), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rstw mem_write dropped", 64'(mem_write), 64'd0);
    check_eq("rstw mem_address cleared", mem_address, 64'd0);
    rq1.req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("rstw no ack", 64'(ack_cnt - s_ack), 64'd0);
    check_eq("rstw word unchanged", mem[5], 64'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 51'd0, giving the value of address[63:13] that selects the attached 64-doubleword memory.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL provide port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide ports req0/req1, input, 1 bit each: access request from requester 0/1.
REQ-006 SHALL provide ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL provide ports addr0/addr1, input, 64 bits each: byte address.
REQ-008 SHALL provide ports wdata0/wdata1, input, 64 bits each: write data.
REQ-009 SHALL provide ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL provide ports err0/err1, output, 1 bit each: valid with ack; access rejected.
REQ-011 SHALL provide ports rdata0/rdata1, output, 64 bits each: read data, valid with ack.
REQ-012 SHALL provide ports mem_read and mem_write, output, 1 bit each: memory strobes.
REQ-013 SHALL provide ports mem_address and mem_data_in, output, 64 bits each: to the memory.
REQ-014 SHALL provide port mem_data_out, input, 64 bits: combinational memory read data.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-016 In IDLE with any req high at a rising edge, SHALL select a winner, latch its we/addr/wdata and go to ACCESS, or to RESP with error set if the access is rejected.
REQ-017 Arbitration SHALL be round-robin: a single requester wins; when both request, the one not served last wins; after reset requester 0 wins the first tie.
REQ-018 SHALL reject an access when addr[2:0] != 0 or addr[63:13] != BASE_ADDRESS, assert no memory strobe for it, and return err=1 with rdata=0.
REQ-019 In ACCESS (exactly one cycle), SHALL drive mem_address = latched address and mem_data_in = latched write data, and assert mem_write if we=1, otherwise mem_read.
REQ-020 Outside ACCESS, SHALL hold mem_read = mem_write = 0; mem_address and mem_data_in hold their last values.
REQ-021 At the edge that ends ACCESS, SHALL capture mem_data_out for reads; the memory commits writes on that same edge.
REQ-022 In RESP (exactly one cycle), SHALL assert the winner's ack with its err and rdata (rdata = 0 for writes), then return to IDLE; the other ack stays 0.
REQ-023 Latency SHALL be: req sampled at edge k gives ack high during cycle k+2 (accepted) or k+1 (rejected); a second access starts no earlier than the edge after RESP.
REQ-024 Handshake: a requester SHALL hold req, we, addr and wdata stable until its ack; the arbiter samples requests only in IDLE and ignores changes after latching.
REQ-025 A req that stays high after its ack SHALL be treated as a new request in the next IDLE cycle.
REQ-026 The last-served pointer SHALL update on each grant, including rejected grants.

Reset
REQ-027 While reset_n = 0, SHALL force state = IDLE, pointer = "requester 1 served last", ack0/ack1/err0/err1/mem_read/mem_write = 0, and rdata0/rdata1/mem_address/mem_data_in = 0.
REQ-028 Reset mid-ACCESS SHALL drop mem_write asynchronously with no ack issued; requesters must reissue the access.

Structure
REQ-029 FSM state encodings and the alignment/range check constants SHALL live in the shared package mem_pkg.
REQ-030 SHALL be a single module with no sub-modules; the arbiter drives the existing 64-doubleword memory unchanged.

Verification
REQ-031 Test: req0 read, addr 0x10, memory preloaded with mem[2] = 2 -> ack0 high at k+2, rdata0 = 2, err0 = 0, one mem_read cycle.
REQ-032 Test: req1 write, addr 0x18, data 0xDEAD, followed by a req0 read of 0x18 -> ack1 at k+2, then rdata0 = 0xDEAD.
REQ-033 Test: req0 and req1 both held high for 4 grants after reset -> grants alternate 0, 1, 0, 1, with no ack ever high on both ports in the same cycle.
REQ-034 Test: req0 to addr 0x0C (unaligned), then to 0x2000 (out of range) -> ack0 with err0 = 1 at k+1, no memory strobe asserted.
REQ-035 Test: reset_n pulsed low during the ACCESS state of a write -> mem_write falls immediately, no ack issued, and the target word is unchanged.
